fnd_scan_decoder: RTL and testbench
===================================

// Module: fnd_scan_decoder
// PURPOSE
//  Receive side of the 4-digit FND scan bus (fnd_com/fnd_seg, active-low common, active-low segments).
//  Samples the multiplexed bus, inverts the 7-seg encoding back to BCD and rebuilds the binary 0..9999 value.
//  Used as a loopback monitor for the display path and as a capture block for boards driving FND-style outputs.
// PARAMETERS
//  SETTLE_CYC   16       cycles fnd_com must stay stable and legal before fnd_seg is sampled
//  TIMEOUT_CYC  200_000  cycles without any fnd_com change before the bus is declared stale
// PORTS
//  clk       in   1   system clock, 100 MHz
//  reset     in   1   asynchronous, active-low reset (asserted at 0)
//  fnd_com   in   4   digit commons; one-hot-low; 1110=digit_1, 1101=digit_10, 1011=digit_100, 0111=digit_1000
//  fnd_seg   in   8   segment pattern for the active digit; bit7 = DP
//  cnt_data  out  14  last good decoded value, 0..9999
//  valid     out  1   1-cycle pulse when cnt_data is updated
//  seg_err   out  1   1-cycle pulse: sampled pattern not in the 16-entry table
//  bcd_err   out  1   1-cycle pulse: complete frame contains a digit A..F
//  stale     out  1   level: no scan activity seen for TIMEOUT_CYC cycles
// BEHAVIOUR
//  - Reset values: cnt_data=0, valid=0, seg_err=0, bcd_err=0, stale=1, digit mask=0, state=IDLE.
//  - Inputs pass through a 2-flop synchronizer; all further timing is counted from the synchronized values.
//  - FSM, per digit dwell:
//    - IDLE: entered when com is illegal (1111 or more than one low bit).
//    - SETTLE: entered on any change to a legal com; counts to SETTLE_CYC-1.
//    - HOLD: entered after one sample is taken; stays until com changes.
//    - Any com change in SETTLE or HOLD restarts SETTLE (or goes to IDLE if illegal). A glitch shorter than SETTLE_CYC is never sampled.
//  - Sample: decode the pattern with the inverse table (c0..8e -> 0..F) and store the nibble in that digit's slot.
//    - Set the mask bit for the digit.
//    - A repeated digit before the frame completes overwrites its slot.
//    - A pattern not in the table pulses seg_err and marks the frame bad. No slot is written and the mask bit is still set.
//  - Frame complete = mask 4'b1111; capture order is irrelevant. The mask clears on completion.
//    - Good frame with all digits <=9: cnt_data = d1000*1000 + d100*100 + d10*10 + d1.
//    - Use a 2-stage pipeline: multiply-add registered, then output registered.
//    - valid pulses 2 cycles after the completing sample.
//    - Any digit A..F: bcd_err pulses, cnt_data is held, no valid.
//    - Bad frame (seg_err seen): no valid, no bcd_err.
//  - Timeout counter clears on every com change and saturates at TIMEOUT_CYC.
//    - On reaching TIMEOUT_CYC: stale=1 and the mask clears; cnt_data is held.
//    - stale=0 on the next valid pulse.
//  - A frame completing in the same cycle the timeout expires is discarded: timeout wins.
//  - Reset mid-frame discards the mask and any frame in the pipeline.
// CONFIGURATION
//  - FND_DP_CAPTURE_EN defined:
//    - Decode uses fnd_seg[6:0] only; bit7 is compared as don't-care.
//    - Extra port dp_out [3:0] out holds the per-digit DP state (1 = lit, i.e. seg[7]==0).
//    - dp_out is updated with cnt_data on valid; reset value 0.
//  - FND_DP_CAPTURE_EN undefined:
//    - The full 8-bit pattern must match the table, so a lit DP gives seg_err.
//    - dp_out is absent.
// STRUCTURE
//  - Package fnd_pkg holds:
//    - SEG_0..SEG_F 8-bit constants shared with the display driver;
//    - COM_D1/D10/D100/D1000 constants;
//    - typedef enum {IDLE, SETTLE, HOLD} fnd_rx_state_t;
//    - FND_MAX = 10_000.
//  - Sub-module fnd_seg_to_bcd (combinational): pattern in -> nibble + hit flag out; the single place the inverse table lives.
// TESTING
//  1. Loop back the display driver with cnt_data=1234 -> within one full scan, valid pulse and cnt_data=1234; repeat with 0 and 9999.
//  2. Force fnd_seg=8'hff on digit_100 for one dwell -> seg_err pulse, no valid that frame; the next clean frame -> valid.
//  3. Drive pattern 8'h88 (A) on digit_10 for a full frame -> bcd_err pulse, cnt_data unchanged.
//  4. com glitch to 1101 for SETTLE_CYC-2 cycles inside a digit_1 dwell -> no sample, mask unchanged.
//  5. Hold com=1111 for TIMEOUT_CYC cycles -> stale=1; resume scanning 0042 -> valid, cnt_data=42, stale=0.
//  6. Assert reset after 3 digits are captured -> all outputs at reset values; the first valid requires 4 fresh digits.

Source files
------------

// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
//   Shared definitions for the 4-digit FND scan bus (active-low commons,
//   active-low segments, bit7 = DP). The segment constants are the same ones
//   the display driver uses. This keeps encoder and decoder on one table.
//
//   Contents:
//     SEG_0..SEG_F        8-bit segment patterns (DP off)
//     COM_D1..COM_D1000   one-hot-low digit commons
//     FND_MAX / CNT_W     value range 0..9999 and its width
//     fnd_rx_state_t      receive FSM states
//     helpers             com legality, com -> slot index, hex detect,
//                         4-digit BCD -> binary
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [3:0] COM_D1    = 4'b1110;
    localparam logic [3:0] COM_D10   = 4'b1101;
    localparam logic [3:0] COM_D100  = 4'b1011;
    localparam logic [3:0] COM_D1000 = 4'b0111;

    localparam int FND_MAX = 10_000;
    localparam int CNT_W   = $clog2(FND_MAX);   // 14 bits covers 0..9999

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } fnd_rx_state_t;

    // Exactly one common low. Everything else, including 1111, is illegal.
    function automatic logic com_is_legal(input logic [3:0] com);
        return (com == COM_D1) || (com == COM_D10) ||
               (com == COM_D100) || (com == COM_D1000);
    endfunction

    // Slot index: 0 = units, 3 = thousands. Only meaningful for legal com.
    function automatic logic [1:0] com_to_idx(input logic [3:0] com);
        logic [1:0] idx;
        idx = 2'd0;
        case (com)
            COM_D10:   idx = 2'd1;
            COM_D100:  idx = 2'd2;
            COM_D1000: idx = 2'd3;
            default:   idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic any_hex(input logic [3:0][3:0] d);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (d[i] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] bcd4_to_bin(input logic [3:0][3:0] d);
        return CNT_W'(d[3]) * CNT_W'(1000) +
               CNT_W'(d[2]) * CNT_W'(100)  +
               CNT_W'(d[1]) * CNT_W'(10)   +
               CNT_W'(d[0]);
    endfunction

endpackage

// File: rtl/fnd_seg_to_bcd.sv
// -----------------------------------------------------------------------------
// fnd_seg_to_bcd
//   Combinational inverse of the 7-segment table: pattern -> nibble 0..F.
//   This is the only place the inverse table lives.
//
//   Ports:
//     seg_i     in  8  active-low segment pattern, bit7 = DP
//     nibble_o  out 4  decoded value (0 when no hit)
//     hit_o     out 1  pattern is one of the 16 table entries
//
//   Configuration:
//     FND_DP_CAPTURE_EN  DP bit is a don't-care. Without it, the full 8 bits
//                        must match, so a lit DP misses.
// -----------------------------------------------------------------------------
module fnd_seg_to_bcd
    import fnd_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       hit_o
);

    logic [7:0] key;

`ifdef FND_DP_CAPTURE_EN
    // Force DP to "off" so the table compare ignores it.
    assign key = {1'b1, seg_i[6:0]};
`else
    assign key = seg_i;
`endif

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        nibble_o = 4'h0;
        hit_o    = 1'b1;
        case (key)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// -----------------------------------------------------------------------------
// fnd_scan_decoder
//   Receive side of the 4-digit FND scan bus. The block syncs the multiplexed
//   bus and waits for each digit's common to settle. It then samples the
//   segments, decodes them back to BCD and rebuilds the 0..9999 value once all
//   four digits have been seen.
//
//   Parameters:
//     SETTLE_CYC   cycles com must be stable and legal before a sample
//     TIMEOUT_CYC  cycles without a com change before the bus is stale
//
//   Ports:
//     clk       in   1   system clock
//     reset     in   1   asynchronous reset, active low
//     fnd_com   in   4   digit commons, one-hot-low
//     fnd_seg   in   8   segment pattern of the active digit, bit7 = DP
//     cnt_data  out  14  last good decoded value
//     valid     out  1   pulse when cnt_data updates
//     seg_err   out  1   pulse: sampled pattern not in the table
//     bcd_err   out  1   pulse: completed frame holds a digit A..F
//     stale     out  1   level: no scan activity for TIMEOUT_CYC cycles
//     dp_out    out  4   per-digit DP state (only with FND_DP_CAPTURE_EN)
//
//   Configuration:
//     FND_DP_CAPTURE_EN  decode ignores DP and the DP bits are reported
//                        on dp_out together with cnt_data
// -----------------------------------------------------------------------------
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       fnd_com,
    input  logic [7:0]       fnd_seg,
    output logic [CNT_W-1:0] cnt_data,
    output logic             valid,
    output logic             seg_err,
    output logic             bcd_err,
    output logic             stale
`ifdef FND_DP_CAPTURE_EN
   ,output logic [3:0]       dp_out
`endif
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    // ---------------------------------------------------------------- sync
    logic [3:0] com_s1_q, com_s2_q, com_last_q;
    logic [7:0] seg_s1_q, seg_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_s1_q   <= 4'hF;
            com_s2_q   <= 4'hF;
            com_last_q <= 4'hF;
            seg_s1_q   <= 8'hFF;
            seg_s2_q   <= 8'hFF;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the chain.
            com_s1_q   <= fnd_com;
            com_s2_q   <= com_s1_q;
            com_last_q <= com_s2_q;
            seg_s1_q   <= fnd_seg;
            seg_s2_q   <= seg_s1_q;
        end
    end

    logic       com_chg;
    logic       com_legal;
    logic [1:0] dig_idx;
    logic [3:0] dig_onehot;

    assign com_chg    = (com_s2_q != com_last_q);
    assign com_legal  = com_is_legal(com_s2_q);
    assign dig_idx    = com_to_idx(com_s2_q);
    assign dig_onehot = 4'(4'b0001 << dig_idx);

    // ---------------------------------------------------------------- dwell FSM
    fnd_rx_state_t    state_q, state_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic             sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            set_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        sample    = 1'b0;
        case (state_q)
            IDLE: begin
                // Illegal -> legal is always a change, so any legal com restarts settling.
                if (com_legal) begin
                    state_d   = SETTLE;
                    set_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (com_chg) begin
                    state_d   = com_legal ? SETTLE : IDLE;
                    set_cnt_d = '0;
                end else if (set_cnt_q == SET_LAST) begin
                    sample  = 1'b1;
                    state_d = HOLD;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (com_chg) begin
                    state_d   = com_legal ? SETTLE : IDLE;
                    set_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- timeout
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_expire;

    // Single-cycle event on the step into saturation. A counter already
    // saturated does not keep re-firing.
    assign tmo_expire = !com_chg && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (com_chg)                  tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    // ---------------------------------------------------------------- frame assembly
    logic [3:0]       dec_nib;
    logic             dec_hit;

    fnd_seg_to_bcd u_seg_to_bcd (
        .seg_i    (seg_s2_q),
        .nibble_o (dec_nib),
        .hit_o    (dec_hit)
    );

    logic [3:0][3:0]  slot_q, slot_d;
    logic [3:0]       mask_q, mask_d;
    logic             bad_q, bad_d;
    logic             frame_done, frame_bad, frame_hex, accept;
    logic             seg_err_d, bcd_err_d, p1_vld_d;
    logic [CNT_W-1:0] sum_d;

    always_comb begin
        slot_d    = slot_q;
        mask_d    = mask_q;
        bad_d     = bad_q;
        seg_err_d = 1'b0;
        if (sample) begin
            mask_d = mask_q | dig_onehot;
            if (dec_hit) begin
                slot_d[dig_idx] = dec_nib;
            end else begin
                seg_err_d = 1'b1;
                bad_d     = 1'b1;
            end
        end

        frame_done = sample && (mask_d == 4'hF);
        frame_bad  = bad_d;
        frame_hex  = any_hex(slot_d);
        // Timeout beats a frame completing in the same cycle.
        accept     = frame_done && !tmo_expire && !frame_bad;
        p1_vld_d   = accept && !frame_hex;
        bcd_err_d  = accept && frame_hex;
        sum_d      = bcd4_to_bin(slot_d);

        if (frame_done || tmo_expire) begin
            mask_d = '0;
            bad_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the four slots are ordinary flops, not a RAM, so they are reset like any other state.
            slot_q    <= '0;
            mask_q    <= '0;
            bad_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            slot_q    <= slot_d;
            mask_q    <= mask_d;
            bad_q     <= bad_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // ---------------------------------------------------------------- output pipeline
    // Stage 1 holds the multiply-add result. Stage 2 is the output register,
    // so valid fires two cycles after the completing sample.
    logic [CNT_W-1:0] sum_q, cnt_data_q;
    logic             p1_vld_q, valid_q, seg_err_q, bcd_err_q, stale_q, stale_d;

    always_comb begin
        stale_d = stale_q;
        if (p1_vld_q)   stale_d = 1'b0;
        if (tmo_expire) stale_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q      <= '0;
            p1_vld_q   <= 1'b0;
            cnt_data_q <= '0;
            valid_q    <= 1'b0;
            seg_err_q  <= 1'b0;
            bcd_err_q  <= 1'b0;
            stale_q    <= 1'b1;
        end else begin
            p1_vld_q  <= p1_vld_d;
            if (p1_vld_d) sum_q <= sum_d;
            valid_q   <= p1_vld_q;
            if (p1_vld_q) cnt_data_q <= sum_q;
            seg_err_q <= seg_err_d;
            bcd_err_q <= bcd_err_d;
            stale_q   <= stale_d;
        end
    end

    assign cnt_data = cnt_data_q;
    assign valid    = valid_q;
    assign seg_err  = seg_err_q;
    assign bcd_err  = bcd_err_q;
    assign stale    = stale_q;

`ifdef FND_DP_CAPTURE_EN
    // ---------------------------------------------------------------- DP capture
    // DP is lit when seg[7] is low. It is tracked per slot and moves through
    // the pipeline alongside the value.
    logic [3:0] dp_slot_q, dp_slot_d, dp_p1_q, dp_out_q;

    always_comb begin
        dp_slot_d = dp_slot_q;
        if (sample) dp_slot_d[dig_idx] = ~seg_s2_q[7];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_slot_q <= '0;
            dp_p1_q   <= '0;
            dp_out_q  <= '0;
        end else begin
            dp_slot_q <= dp_slot_d;
            if (p1_vld_d) dp_p1_q  <= dp_slot_d;
            if (p1_vld_q) dp_out_q <= dp_p1_q;
        end
    end

    assign dp_out = dp_out_q;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_decoder
//   Directed bench for fnd_scan_decoder. A small display-driver model scans
//   the digits d1, d10, d100, d1000 with a fixed dwell. Pulse outputs are
//   counted on the falling edge. Each scenario compares the count deltas and
//   the held outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fnd_scan_decoder;

    localparam int SETTLE = 16;
    localparam int TMO    = 2000;
    localparam int DW     = 32;   // dwell per digit: 2 sync + 1 edge detect + 16 settle fits
    localparam int GAP    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_seg;
    logic [13:0] cnt_data;
    logic        valid, seg_err, bcd_err, stale;
`ifdef FND_DP_CAPTURE_EN
    logic [3:0]  dp_out;
`endif

    fnd_scan_decoder #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fnd_com  (fnd_com),
        .fnd_seg  (fnd_seg),
        .cnt_data (cnt_data),
        .valid    (valid),
        .seg_err  (seg_err),
        .bcd_err  (bcd_err),
        .stale    (stale)
`ifdef FND_DP_CAPTURE_EN
       ,.dp_out   (dp_out)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_segerr = 0;
    int n_bcderr = 0;
    int v0, s0, b0;

    always @(negedge clk) begin
        if (valid)   n_valid  <= n_valid + 1;
        if (seg_err) n_segerr <= n_segerr + 1;
        if (bcd_err) n_bcderr <= n_bcderr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark();
        v0 = n_valid;
        s0 = n_segerr;
        b0 = n_bcderr;
    endtask

    task automatic drive(input logic [3:0] com, input logic [7:0] seg, input int n);
        fnd_com = com;
        fnd_seg = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_pat(input logic [7:0] p1, input logic [7:0] p10,
                            input logic [7:0] p100, input logic [7:0] p1000);
        drive(4'b1110, p1,    DW);
        drive(4'b1101, p10,   DW);
        drive(4'b1011, p100,  DW);
        drive(4'b0111, p1000, DW);
        drive(4'b1111, 8'hFF, GAP);
    endtask

    task automatic scan_val(input int v);
        scan_pat(seg_tbl[v % 10], seg_tbl[(v / 10) % 10],
                 seg_tbl[(v / 100) % 10], seg_tbl[(v / 1000) % 10]);
    endtask

    initial begin
        reset   = 1'b0;
        fnd_com = 4'hF;
        fnd_seg = 8'hFF;
        repeat (4) @(negedge clk);

        // Reset values
        check("rst cnt_data", cnt_data, 0);
        check("rst valid",    valid,    0);
        check("rst seg_err",  seg_err,  0);
        check("rst bcd_err",  bcd_err,  0);
        check("rst stale",    stale,    1);
        reset = 1'b1;
        drive(4'hF, 8'hFF, 4);

        // Loopback of three values
        mark(); scan_val(1234);
        check("lb1234 valid cnt", n_valid - v0, 1);
        check("lb1234 data",      cnt_data,     1234);
        check("lb1234 stale",     stale,        0);
        mark(); scan_val(0);
        check("lb0 valid cnt",    n_valid - v0, 1);
        check("lb0 data",         cnt_data,     0);
        mark(); scan_val(9999);
        check("lb9999 valid cnt", n_valid - v0, 1);
        check("lb9999 data",      cnt_data,     9999);

        // Unknown pattern on digit_100 poisons the frame
        mark(); scan_pat(seg_tbl[3], seg_tbl[2], 8'hFF, seg_tbl[1]);
        check("segerr pulses",    n_segerr - s0, 1);
        check("segerr no valid",  n_valid - v0,  0);
        check("segerr no bcderr", n_bcderr - b0, 0);
        check("segerr data held", cnt_data,      9999);
        mark(); scan_val(5678);
        check("after segerr valid", n_valid - v0, 1);
        check("after segerr data",  cnt_data,     5678);

        // Hex digit A on digit_10
        mark(); scan_pat(seg_tbl[1], 8'h88, seg_tbl[2], seg_tbl[3]);
        check("bcderr pulses",    n_bcderr - b0, 1);
        check("bcderr no valid",  n_valid - v0,  0);
        check("bcderr no segerr", n_segerr - s0, 0);
        check("bcderr data held", cnt_data,      5678);

        // Lit DP on digit_1 (1 with DP = 8'h79)
        mark(); scan_pat(8'h79, seg_tbl[2], seg_tbl[3], seg_tbl[4]);
`ifdef FND_DP_CAPTURE_EN
        check("dp valid cnt", n_valid - v0, 1);
        check("dp data",      cnt_data,     4321);
        check("dp_out",       dp_out,       4'b0001);
`else
        check("dp segerr",    n_segerr - s0, 1);
        check("dp no valid",  n_valid - v0,  0);
        check("dp data held", cnt_data,      5678);
`endif

        // Short com glitch inside a digit_1 dwell must not be sampled.
        // Mask is {d1000,d100,d1} when the glitch hits, so a sampled
        // glitch would complete the frame early.
        mark();
        drive(4'b0111, seg_tbl[7], DW);
        drive(4'b1011, seg_tbl[6], DW);
        drive(4'b1110, seg_tbl[9], 24);
        drive(4'b1101, seg_tbl[0], SETTLE - 2);
        drive(4'b1110, seg_tbl[9], 24);
        check("glitch no valid", n_valid - v0, 0);
        drive(4'b1101, seg_tbl[5], DW);
        drive(4'b1111, 8'hFF, GAP);
        check("glitch then d10 valid", n_valid - v0, 1);
        check("glitch then d10 data",  cnt_data,     7659);

        // Timeout: partial frame, idle bus, then resume with 0042
        drive(4'b0111, seg_tbl[9], DW);
        drive(4'b1011, seg_tbl[9], DW);
        drive(4'b1111, 8'hFF, TMO - 10);
        check("stale before tmo", stale, 0);
        drive(4'b1111, 8'hFF, 20);
        check("stale after tmo",  stale, 1);
        check("tmo data held",    cnt_data, 7659);
        mark();
        drive(4'b1101, seg_tbl[4], DW);
        drive(4'b1110, seg_tbl[2], DW);
        check("tmo mask cleared", n_valid - v0, 0);
        drive(4'b0111, seg_tbl[0], DW);
        drive(4'b1011, seg_tbl[0], DW);
        drive(4'b1111, 8'hFF, GAP);
        check("resume valid cnt", n_valid - v0, 1);
        check("resume data",      cnt_data,     42);
        check("resume stale",     stale,        0);

        // Reset after three captured digits
        drive(4'b1110, seg_tbl[5], DW);
        drive(4'b1101, seg_tbl[6], DW);
        drive(4'b1011, seg_tbl[7], DW);
        fnd_com = 4'hF;
        fnd_seg = 8'hFF;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst cnt_data", cnt_data, 0);
        check("midrst stale",    stale,    1);
        check("midrst valid",    valid,    0);
        reset = 1'b1;
        drive(4'hF, 8'hFF, 4);
        mark();
        drive(4'b0111, seg_tbl[8], DW);
        drive(4'b1111, 8'hFF, GAP);
        check("midrst mask discarded", n_valid - v0, 0);
        scan_val(8765);
        check("midrst fresh valid", n_valid - v0, 1);
        check("midrst fresh data",  cnt_data,     8765);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
